fifo_null_pages: RTL and testbench

- Free-page ("null page") list for a paged packet buffer.
- Holds up to 2048 11-bit page addresses as a circular FIFO.
- The allocator pops the head page; the deallocator pushes released pages at the tail.
- After reset the list is full, holding pages 0..2047 in ascending order.

---
 rtl/fifo_null_pages_pkg.sv | 11 +
 rtl/fifo_null_pages.sv | 64 ++++++
 tb/tb_fifo_null_pages.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fifo_null_pages_pkg.sv
// Shared page-address types for the packet buffer free-page list.
// Used by the allocator, deallocator and the null-page FIFO.
package fifo_null_pages_pkg;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  typedef logic [ADDR_W-1:0] page_addr_t;
  typedef logic [ADDR_W:0]   page_cnt_t;

endpackage

// File: rtl/fifo_null_pages.sv
// Free-page FIFO: pops hand pages to the allocator, pushes return them.
// Comes out of reset full, holding every page in ascending order.
module fifo_null_pages
  import fifo_null_pages_pkg::*;
(
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              pop_head,
  output logic [ADDR_W-1:0] head_addr,
  input  logic              push_tail,
  input  logic [ADDR_W-1:0] tail_addr,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  page_addr_t mem [DEPTH];
  page_addr_t head_ptr;
  page_addr_t tail_ptr;
  page_cnt_t  cnt_q;

  logic pop_ok;
  logic push_ok;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == page_cnt_t'(DEPTH));
  assign count     = cnt_q;
  assign head_addr = mem[head_ptr];

  // A full FIFO still takes a push when a pop frees the head slot.
  assign pop_ok  = pop_head & ~empty;
  assign push_ok = push_tail & (~full | pop_ok);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= page_addr_t'(i);
      end
    end else if (push_ok) begin
      mem[tail_ptr] <= tail_addr;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      cnt_q    <= page_cnt_t'(DEPTH);
    end else begin
      if (pop_ok) begin
        head_ptr <= head_ptr + 1'b1;
      end
      if (push_ok) begin
        tail_ptr <= tail_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_null_pages.sv
// Directed bench for the free-page FIFO.
// Expected values are hand-derived from the page sequence.
module tb_fifo_null_pages;

  import fifo_null_pages_pkg::*;

  logic              sys_clk;
  logic              rst_n;
  logic              pop_head;
  logic [ADDR_W-1:0] head_addr;
  logic              push_tail;
  logic [ADDR_W-1:0] tail_addr;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;

  int n_checks;
  int n_fail;
  int bad;
  logic [ADDR_W-1:0] q [$];

  fifo_null_pages dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .pop_head  (pop_head),
    .head_addr (head_addr),
    .push_tail (push_tail),
    .tail_addr (tail_addr),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  function automatic logic [ADDR_W-1:0] pat(input int k);
    return ADDR_W'((k * 7 + 3) % 2048);
  endfunction

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    pop_head  = 1'b0;
    push_tail = 1'b0;
    tail_addr = '0;
    repeat (10) @(negedge sys_clk);
    rst_n = 1'b1;

    check("rst_head", 32'(head_addr), 0);
    check("rst_count", 32'(count), 2048);
    check("rst_full", 32'(full), 1);
    check("rst_empty", 32'(empty), 0);

    // Sequential pop of 2046 pages
    pop_head = 1'b1;
    for (int i = 0; i < 2046; i++) begin
      check("seq_head", 32'(head_addr), i);
      step();
    end
    check("seq_head_end", 32'(head_addr), 2046);
    check("seq_count_end", 32'(count), 2);

    // Wrap with concurrent push, count holds at 2
    push_tail = 1'b1;
    for (int k = 0; k < 256; k++) begin
      tail_addr = ADDR_W'(k);
      check("wrap_head", 32'(head_addr), (k < 2) ? 2046 + k : k - 2);
      check("wrap_count", 32'(count), 2);
      step();
    end
    q.delete();
    q.push_back(ADDR_W'(254));
    q.push_back(ADDR_W'(255));
    check("wrap_head_end", 32'(head_addr), 254);

    // Refill with a distinct pattern
    pop_head = 1'b0;
    for (int k = 0; k < 2046; k++) begin
      tail_addr = pat(k);
      q.push_back(pat(k));
      step();
    end
    check("refill_count", 32'(count), 2048);
    check("refill_full", 32'(full), 1);
    check("refill_tail", 32'(dut.tail_ptr), 254);
    tail_addr = ADDR_W'(11'h555);
    step();
    check("drop_count", 32'(count), 2048);
    check("drop_tail", 32'(dut.tail_ptr), 254);
    check("drop_head", 32'(head_addr), 254);
    push_tail = 1'b0;

    // Drain to empty
    pop_head = 1'b1;
    for (int k = 0; k < 2048; k++) begin
      check("drain_head", 32'(head_addr), 32'(q[k]));
      step();
    end
    check("drain_empty", 32'(empty), 1);
    check("drain_count", 32'(count), 0);
    step();
    check("xpop_count", 32'(count), 0);
    check("xpop_head_ptr", 32'(dut.head_ptr), 254);

    // Push and pop on empty: only the push acts
    push_tail = 1'b1;
    tail_addr = ADDR_W'(5);
    step();
    push_tail = 1'b0;
    pop_head  = 1'b0;
    check("emp_pp_count", 32'(count), 1);
    check("emp_pp_head", 32'(head_addr), 5);
    check("emp_pp_empty", 32'(empty), 0);

    // Async reset between edges during traffic
    pop_head  = 1'b1;
    push_tail = 1'b1;
    tail_addr = ADDR_W'(9);
    step();
    step();
    @(posedge sys_clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_count", 32'(count), 2048);
    check("areset_head", 32'(head_addr), 0);
    check("areset_full", 32'(full), 1);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (dut.mem[i] !== ADDR_W'(i)) bad++;
    end
    check("areset_mem", 32'(bad), 0);
    @(negedge sys_clk);
    pop_head  = 1'b0;
    push_tail = 1'b0;
    rst_n     = 1'b1;
    step();
    check("areset_hold", 32'(count), 2048);

    // Push and pop on full: write lands in the vacated slot
    pop_head  = 1'b1;
    push_tail = 1'b1;
    tail_addr = ADDR_W'(11'h123);
    step();
    pop_head  = 1'b0;
    push_tail = 1'b0;
    check("full_pp_count", 32'(count), 2048);
    check("full_pp_head", 32'(head_addr), 1);
    check("full_pp_tail", 32'(dut.tail_ptr), 1);
    check("full_pp_mem0", 32'(dut.mem[0]), 32'h123);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
